sort_scheduler: RTL
===================

# sort_scheduler

Controller that shares one instance of the team's single-cycle `sorting` engine between up to `NREQ` requesters. It arbitrates round-robin and stages the winner's `M` words in an internal buffer, so requesters may stall. It then feeds the sorter the contiguous `load_enable` burst it requires, waits out the fixed sort latency, and streams the sorted words back tagged with the owner's ID. It sits directly above the sorter in the sort subsystem.

## Interface
Parameters:
- `M`, 15: words per job; must equal the sorter's `m`.
- `N`, 8: word width; must equal the sorter's `n`.
- `NREQ`, 4: number of requesters, 2..8.
- `SORT_LAT`, `M+1`: cycles from the end of the feed burst to the first valid sorter output.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low; 0 resets.
- `req`, in, `NREQ`: per-requester job request, level.
- `req_type`, in, `NREQ`: per-requester order; 0 ascending, 1 descending.
- `gnt`, out, `NREQ`: one-hot grant, held for the whole job.
- `in_data`, in, `N`: word from the granted requester.
- `in_valid`, in, 1: `in_data` valid.
- `in_ready`, out, 1: the scheduler accepts a word when `in_valid & in_ready`.
- `out_data`, out, `N`: sorted word.
- `out_valid`, out, 1: `out_data` valid; there is no backpressure.
- `out_last`, out, 1: marks the M-th word.
- `out_id`, out, `clog2(NREQ)`: owner of `out_data`.
- `busy`, out, 1: high in any state except IDLE.
- `srt_reset`, out, 1: sorter synchronous reset, active-high.
- `srt_load_enable`, out, 1: to sorter `load_enable`.
- `srt_sort_type`, out, 1: to sorter `sortType`.
- `srt_data_in`, out, `N`: to sorter `data_in`.
- `srt_data_out`, in, `N`: from sorter `data_out`.

## Operation
FSM states: IDLE, FILL, FEED, SORT, DRAIN.
- **IDLE**
  - `srt_reset=1`.
  - If any `req` bit is set: the round-robin arbiter picks the winner, starting from the requester after the last one granted.
  - Register `gnt`, `out_id` and the type (from `req_type[winner]`).
  - Go to FILL.
- **FILL**
  - `srt_reset=1`; `in_ready=1` while `fill_cnt<M`.
  - Each accepted word is written to `buf[fill_cnt]` and `fill_cnt` increments.
  - Gaps in `in_valid` are allowed.
  - When the M-th word is accepted, go to FEED.
- **FEED**, exactly M cycles
  - `srt_reset=0`, `srt_load_enable=1`, `srt_data_in=buf[feed_cnt]` for `feed_cnt` = 0..M-1, with no gaps.
  - Then go to SORT.
- **SORT**, exactly `SORT_LAT` cycles
  - `srt_load_enable=0`, `srt_reset=0`.
  - Counts `wait_cnt`, then goes to DRAIN.
- **DRAIN**, exactly M cycles
  - `out_valid=1`, `out_data=srt_data_out` (combinational pass-through).
  - `out_last=1` on the M-th cycle.
  - Then: clear `gnt`, advance the arbiter pointer past the winner, go to IDLE.
- `srt_sort_type` is the latched type, held stable from grant through DRAIN. The sorter re-evaluates `sortType` every cycle.
- `srt_reset` is held high in IDLE/FILL so the sorter never free-runs on stale data.
- Once granted, the job completes regardless of `req`; deasserting `req` mid-job is ignored.
- A requester holding `req` after its job re-enters arbitration behind the others.
- `in_valid` outside FILL is ignored. `in_ready` is 0 in every other state.
- Counters are `clog2(M+1)` bits (`fill_cnt`, `feed_cnt`) and `clog2(SORT_LAT+1)` bits (`wait_cnt`); all clear on state entry. There is no wrap-around.

## Timing
- Reset (async assert, sync release): state=IDLE, `gnt=0`, `in_ready=0`, `out_valid=0`, `out_last=0`, `out_id=0`, `busy=0`, `srt_reset=1`, `srt_load_enable=0`, `srt_sort_type=0`, `srt_data_in=0`. The arbiter pointer is set to requester 0.
- Reset mid-job aborts the job. No partial output is flagged, and the sorter is cleared via `srt_reset=1`.
- Minimum job time is 1 + M + M + `SORT_LAT` + M cycles: grant → FILL with no gaps → FEED → SORT → DRAIN. This is 62 cycles at defaults.
- `gnt` rises the cycle after IDLE sees `req` and falls the cycle after `out_last`.
- Back-to-back jobs leave one IDLE cycle between jobs.

## Structure
- Package `sort_pkg`: state enum `sched_state_t`, plus localparams for the default `M`, `N`, `NREQ` and the derived counter widths.
- Sub-module `rr_arbiter`:
  - Inputs: `req`, `advance`.
  - Output: one-hot `gnt`.
  - Holds the rotating pointer.
- The staging buffer is inline, M×N flops with no RAM. The sorter is instantiated by the parent, not inside this block.

## Test plan
- Requester 0, type 0, loads 15,14,…,1 with no gaps → `gnt=0001`; DRAIN outputs 1..15, `out_last` on 15, `out_id=0`; total 62 cycles.
- Requester 2, type 1, loads 3,200,3,0,255,7,7,… with duplicates → descending output 255,200,…,0, duplicates preserved.
- FILL with `in_valid` toggling every other cycle → `srt_load_enable` is still high for exactly 15 contiguous cycles; output is correct.
- `req=1111` held continuously → grants 0,1,2,3,0 in order, each job complete before the next `gnt`.
- `reset=0` for one cycle during DRAIN word 5 → all outputs return to reset values immediately; the next job runs clean with no stale words.
- `req` dropped during SORT → the job still drains all 15 words to that `out_id`.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and defaults for the sort scheduler slice.
package sort_pkg;

  localparam int M_DEF      = 15;
  localparam int N_DEF      = 8;
  localparam int NREQ_DEF   = 4;
  localparam int CNT_W_DEF  = $clog2(M_DEF + 1);
  localparam int WAIT_W_DEF = $clog2(M_DEF + 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_FEED,
    ST_SORT,
    ST_DRAIN
  } sched_state_t;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i[2:0]]) r = i[2:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sort_scheduler_rr_arbiter.sv
// Round-robin arbiter; search starts at the requester after the last winner.
module rr_arbiter
  import sort_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cidx;
  logic           found;
  int             cand;

  // First requesting index at or after the pointer, wrapping around.
  always_comb begin
    gnt   = '0;
    win   = ptr;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = cand[IDW-1:0];
      if (!found && req[cidx]) begin
        gnt[cidx] = 1'b1;
        win       = cidx;
        found     = 1'b1;
      end
    end
  end

  // Pointer moves one past the winner when the owning job retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/sort_scheduler.sv
// Shares one sorting engine between NREQ requesters: stage, feed, wait, drain.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | sorter held in reset, arbitrate pending requests
//   FILL     | accept M words from the granted requester into stage_buf
//   FEED     | M-cycle contiguous load_enable burst into the sorter
//   SORT     | wait SORT_LAT cycles for the first sorted word
//   DRAIN    | pass M sorted words out tagged with the owner id
module sort_scheduler
  import sort_pkg::*;
#(
  parameter int M        = M_DEF,
  parameter int N        = N_DEF,
  parameter int NREQ     = NREQ_DEF,
  parameter int SORT_LAT = M + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_type,
  output logic [NREQ-1:0]         gnt,
  input  logic [N-1:0]            in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N-1:0]            out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic                    busy,
  output logic                    srt_reset,
  output logic                    srt_load_enable,
  output logic                    srt_sort_type,
  output logic [N-1:0]            srt_data_in,
  input  logic [N-1:0]            srt_data_out
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(M + 1);
  localparam int WW  = $clog2(SORT_LAT + 1);

  sched_state_t    state, state_nxt;
  logic [CW-1:0]   fill_cnt;
  logic [CW-1:0]   feed_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            sort_type_q;
  logic [N-1:0]    stage_buf [M];
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] arb_gnt;
  logic            arb_advance;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (arb_advance),
    .gnt     (arb_gnt)
  );

  assign srt_sort_type = sort_type_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and all per-state outputs; feed_cnt doubles as the drain index.
  // Outside IDLE the arbiter sees only the latched grant so that advance
  // moves the pointer past the job owner.
  always_comb begin
    state_nxt       = state;
    busy            = 1'b1;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    out_last        = 1'b0;
    out_data        = '0;
    srt_reset       = 1'b0;
    srt_load_enable = 1'b0;
    srt_data_in     = '0;
    arb_req         = gnt;
    arb_advance     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        srt_reset = 1'b1;
        arb_req   = req;
        if (|req) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        srt_reset = 1'b1;
        in_ready  = (fill_cnt < CW'(M));
        if (in_valid && in_ready && fill_cnt == CW'(M - 1)) state_nxt = ST_FEED;
      end
      ST_FEED: begin
        srt_load_enable = 1'b1;
        srt_data_in     = stage_buf[feed_cnt];
        if (feed_cnt == CW'(M - 1)) state_nxt = ST_SORT;
      end
      ST_SORT: begin
        if (wait_cnt == WW'(SORT_LAT - 1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_data  = srt_data_out;
        if (feed_cnt == CW'(M - 1)) begin
          out_last    = 1'b1;
          arb_advance = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Phase counters; every state entry starts them from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt <= '0;
      feed_cnt <= '0;
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      fill_cnt <= '0;
      feed_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == ST_FILL && in_valid && in_ready) fill_cnt <= fill_cnt + 1'b1;
      if (state == ST_FEED || state == ST_DRAIN)    feed_cnt <= feed_cnt + 1'b1;
      if (state == ST_SORT)                         wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Job ownership: grant, id and order are latched at grant and held to DRAIN end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt         <= '0;
      out_id      <= '0;
      sort_type_q <= 1'b0;
    end else if (state == ST_IDLE && |req) begin
      gnt         <= arb_gnt;
      out_id      <= IDW'(onehot_to_idx(8'(arb_gnt)));
      sort_type_q <= |(req_type & arb_gnt);
    end else if (arb_advance) begin
      gnt <= '0;
    end
  end

  // Staging buffer; fully rewritten in FILL before every FEED, so no reset.
  always_ff @(posedge clk) begin
    if (state == ST_FILL && in_valid && in_ready) stage_buf[fill_cnt] <= in_data;
  end

endmodule
